div_ctrl: RTL and testbench
===========================

# div_ctrl

Multi-cycle divide sequencer for the HI/LO unit. It accepts a DIV/DIVU from the Execute stage, holds the pipeline with a stall request while a radix-2 restoring divider iterates, then presents quotient and remainder for the HI/LO write that `hilowriteM` commits. Flush or exception cancel aborts it at any point.

## Interface
Parameters:
- `WIDTH`, 32: operand width.
- `CNT_W`, 6: iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `startE` in 1: a DIV/DIVU instruction is in the E stage. Stays high while E is stalled.
- `signedE` in 1: 1 = DIV, 0 = DIVU.
- `srcaE` in WIDTH: dividend.
- `srcbE` in WIDTH: divisor.
- `cancel` in 1: flushE or exception. Aborts any operation in progress.
- `stall_div` out 1: request to the hazard unit to stall F/D/E.
- `ready` out 1: result is valid this cycle.
- `lo` out WIDTH: quotient.
- `hi` out WIDTH: remainder.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - On `startE & ~cancel`:
    - Latch |srcaE| and |srcbE|. Absolute value applies only when `signedE`; otherwise the raw value is used.
    - Latch sign_q = a[31]^b[31] and sign_r = a[31]. Both are 0 when unsigned.
    - Clear the counter.
    - If the divisor is 0, go to DONE. Otherwise go to BUSY.
- BUSY: one restoring step per cycle.
  - Shift {rem,quo} left by 1.
  - Trial-subtract the divisor at WIDTH+1 bits.
  - If the trial result is non-negative, keep it in rem and set quo[0] = 1.
  - After the WIDTH-th step (counter = WIDTH−1), go to DONE.
- DONE:
  - `ready` = 1.
  - Load `lo` = sign_q ? −quo : quo.
  - Load `hi` = sign_r ? −rem : rem.
  - Next state is IDLE unconditionally. A `startE` seen in DONE is ignored, because it is the same instruction leaving E.
- Divide by zero (decided behaviour): `lo` = all ones, `hi` = the dividend as given. No sign fixup is applied.
- 0x80000000 / 0xFFFFFFFF, signed: `lo` = 0x80000000, `hi` = 0. This falls out of the unsigned magnitude path with no special case.
- `stall_div` = ~cancel & ((IDLE & startE) | BUSY). It is combinational, so E never advances on the start cycle.
- `cancel`:
  - From any state, next state is IDLE.
  - `ready` is suppressed in the same cycle.
  - `hi` and `lo` are not updated.
- `hi` and `lo` are registered. They hold their value until the next DONE.
- Reset:
  - State = IDLE.
  - Counter, working registers, `hi` and `lo` = 0.
  - `ready` = 0 and `stall_div` = 0, given `startE` = 0.
  - Reset mid-operation discards the operation.

## Timing
- Normal divide: `stall_div` is high for WIDTH+1 cycles (33): the start cycle plus 32 BUSY cycles.
- `ready` is high in the next cycle, which is DONE. `hi` and `lo` are valid from that edge onward.
- The E stage advances at the end of the DONE cycle, so M sees the result.
- Divide by zero: 1 stall cycle, then DONE.
- Back-to-back divides: the earliest new start is the cycle after DONE.
- `cancel` together with `startE` in IDLE: the operation does not start and `stall_div` = 0.

## Structure
- Shared package `div_pkg`:
  - State encoding: DIV_IDLE, DIV_BUSY, DIV_DONE.
  - DIV_ITER = 32.
  - DIV0_QUO = 32'hFFFFFFFF.
- Sub-module `div_step`: combinational single restoring step.
  - Inputs: {rem,quo} and the divisor.
  - Outputs: the next {rem,quo}.
  - It is instantiated once inside `div_ctrl`.
- `div_ctrl` owns the FSM, the counter, the sign latches and the fixup negators.

## Test plan
- Unsigned 100 / 7:
  - `stall_div` high for 33 cycles.
  - `ready` pulses once.
  - `lo` = 14, `hi` = 2.
- Signed −7 / 2 (0xFFFFFFF9 / 2): `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
- Unsigned 5 / 0:
  - 1 stall cycle, then `ready`.
  - `lo` = 0xFFFFFFFF, `hi` = 5.
- Signed 0x80000000 / 0xFFFFFFFF: `lo` = 0x80000000, `hi` = 0.
- `cancel` pulsed in BUSY iteration 10:
  - `stall_div` drops the same cycle.
  - State is IDLE next cycle.
  - No `ready` pulse.
  - `hi`/`lo` keep their previous values.
  - A new 9 / 3 then completes with `lo` = 3, `hi` = 0.
- `rst` asserted mid-BUSY:
  - All outputs go to 0 immediately (asynchronous).
  - After release with `startE` = 0, the block stays IDLE and `stall_div` = 0.

Source files
------------

// File: rtl/div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_pkg                                                              |
// | Shared state encoding and constants for the HI/LO divide sequencer.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Number of restoring iterations for a full-width divide.
  localparam int DIV_ITER = 32;

  // Quotient reported for a zero divisor.
  localparam logic [31:0] DIV0_QUO = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_step                                                             |
// | One radix-2 restoring division step: shift {rem,quo} left by one,    |
// | trial-subtract the divisor and keep the difference if non-negative.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The shifted partial remainder needs WIDTH+1 bits: rem < dvs, so after
  // the shift it may exceed WIDTH bits before the subtraction.
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs};

  // Restore on a negative trial, otherwise commit the difference.
  always_comb begin
    rem_next = shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule
`default_nettype wire

// File: rtl/div_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_ctrl                                                             |
// | Multi-cycle DIV/DIVU sequencer: stalls F/D/E while a restoring       |
// | divider iterates, then presents quotient (lo) and remainder (hi).    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module div_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,        // asynchronous, active low
  input  logic             startE,
  input  logic             signedE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             cancel,
  output logic             stall_div,
  output logic             ready,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  div_state_t       state;
  div_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             start_ok;
  logic             div_zero;
  logic             last_step;
  logic             stall_raw;

  assign a_neg     = signedE & srcaE[WIDTH-1];
  assign b_neg     = signedE & srcbE[WIDTH-1];
  assign abs_a     = a_neg ? -srcaE : srcaE;
  assign abs_b     = b_neg ? -srcbE : srcbE;
  assign start_ok  = startE & ~cancel;
  assign div_zero  = (srcbE == '0);
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  div_step #(
    .WIDTH    (WIDTH)
  ) u_step (
    .rem      (rem),
    .quo      (quo),
    .dvs      (dvs),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= DIV_IDLE;
    else      state <= state_next;
  end

  // Next-state, stall request and ready; cancel overrides everything.
  always_comb begin
    state_next = state;
    stall_raw  = 1'b0;
    ready      = 1'b0;
    case (state)
      DIV_IDLE: begin
        stall_raw = start_ok;
        if (start_ok) state_next = div_zero ? DIV_DONE : DIV_BUSY;
      end
      DIV_BUSY: begin
        stall_raw = ~cancel;
        if (last_step) state_next = DIV_DONE;
      end
      DIV_DONE: begin
        // A startE here is the finished instruction still sitting in E.
        ready      = ~cancel;
        state_next = DIV_IDLE;
      end
      default: state_next = DIV_IDLE;
    endcase
    if (cancel) state_next = DIV_IDLE;
  end

  // Held low while reset is asserted so the hazard unit sees no stall.
  assign stall_div = rst & stall_raw;

  // Working registers, counter, sign latches and result registers. The
  // result is written on the edge that enters DONE so it is valid while
  // ready is high and holds until the next completed divide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      lo     <= '0;
      hi     <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start_ok) begin
            rem    <= '0;
            quo    <= abs_a;
            dvs    <= abs_b;
            sign_q <= a_neg ^ b_neg;
            sign_r <= a_neg;
            cnt    <= '0;
            if (div_zero) begin
              // Raw dividend and all-ones quotient, no sign fixup.
              lo <= '1;
              hi <= srcaE;
            end
          end
        end
        DIV_BUSY: begin
          if (!cancel) begin
            rem <= rem_step;
            quo <= quo_step;
            cnt <= cnt + CNT_W'(1);
            if (last_step) begin
              lo <= sign_q ? -quo_step : quo_step;
              hi <= sign_r ? -rem_step : rem_step;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_div_ctrl                                                          |
// | Self-checking bench for div_ctrl: directed corner cases plus random  |
// | divides compared against an arithmetic reference model.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_div_ctrl;

  logic        clk;
  logic        rst;
  logic        startE;
  logic        signedE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic        cancel;
  logic        stall_div;
  logic        ready;
  logic [31:0] lo;
  logic [31:0] hi;

  int total;
  int bad;

  div_ctrl #(
    .WIDTH     (32),
    .CNT_W     (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .startE    (startE),
    .signedE   (signedE),
    .srcaE     (srcaE),
    .srcbE     (srcbE),
    .cancel    (cancel),
    .stall_div (stall_div),
    .ready     (ready),
    .lo        (lo),
    .hi        (hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division (truncating, remainder takes the
  // dividend's sign), done at 64 bits so MIN/-1 does not overflow.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // One full divide: count stall cycles, expect one ready pulse with the
  // model's result, then E advances (startE drops) and the result holds.
  task automatic run_div(input string tag, input logic [31:0] a,
                         input logic [31:0] b, input logic s);
    logic [31:0] eq;
    logic [31:0] er;
    int          stalls;
    int          early_ready;
    ref_div(a, b, s, eq, er);
    @(negedge clk);
    startE  = 1'b1;
    signedE = s;
    srcaE   = a;
    srcbE   = b;
    #1;
    stalls      = 0;
    early_ready = 0;
    while (stall_div === 1'b1 && stalls < 100) begin
      if (ready !== 1'b0) early_ready++;
      stalls++;
      @(negedge clk);
      #1;
    end
    check({tag, ".stalls"}, stalls, (b == 32'd0) ? 32'd1 : 32'd33);
    check({tag, ".early_ready"}, early_ready, 32'd0);
    check({tag, ".ready"}, {31'd0, ready}, 32'd1);
    check({tag, ".lo"}, lo, eq);
    check({tag, ".hi"}, hi, er);
    @(negedge clk);
    startE = 1'b0;
    #1;
    check({tag, ".ready_once"}, {31'd0, ready}, 32'd0);
    check({tag, ".idle_stall"}, {31'd0, stall_div}, 32'd0);
    check({tag, ".lo_hold"}, lo, eq);
    check({tag, ".hi_hold"}, hi, er);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    int          sel;
    logic [31:0] keep_lo;
    logic [31:0] keep_hi;

    total   = 0;
    bad     = 0;
    rst     = 1'b0;
    startE  = 1'b0;
    signedE = 1'b0;
    srcaE   = '0;
    srcbE   = '0;
    cancel  = 1'b0;

    #12;
    check("rst.lo", lo, 32'd0);
    check("rst.hi", hi, 32'd0);
    check("rst.ready", {31'd0, ready}, 32'd0);
    check("rst.stall", {31'd0, stall_div}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed cases.
    run_div("u100_7", 32'd100, 32'd7, 1'b0);
    run_div("s-7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_div("u5_0", 32'd5, 32'd0, 1'b0);
    run_div("smin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_div("s-9_0", 32'hFFFF_FFF7, 32'd0, 1'b1);

    // Cancel during BUSY iteration 10.
    keep_lo = 32'hFFFF_FFFF;
    keep_hi = 32'hFFFF_FFF7;
    @(negedge clk);
    startE  = 1'b1;
    signedE = 1'b0;
    srcaE   = 32'd100;
    srcbE   = 32'd7;
    repeat (11) @(negedge clk);
    cancel = 1'b1;
    #1;
    check("cancel.stall", {31'd0, stall_div}, 32'd0);
    check("cancel.ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    cancel = 1'b0;
    startE = 1'b0;
    #1;
    check("cancel.idle_stall", {31'd0, stall_div}, 32'd0);
    check("cancel.idle_ready", {31'd0, ready}, 32'd0);
    check("cancel.lo_keep", lo, keep_lo);
    check("cancel.hi_keep", hi, keep_hi);
    run_div("u9_3", 32'd9, 32'd3, 1'b0);

    // Cancel together with start in IDLE: nothing may start (a zero
    // divisor would otherwise show ready on the next cycle).
    @(negedge clk);
    startE = 1'b1;
    cancel = 1'b1;
    srcaE  = 32'd77;
    srcbE  = 32'd0;
    #1;
    check("cstart.stall", {31'd0, stall_div}, 32'd0);
    @(negedge clk);
    startE = 1'b0;
    cancel = 1'b0;
    #1;
    check("cstart.ready", {31'd0, ready}, 32'd0);
    check("cstart.lo_keep", lo, 32'd3);

    // Random divides.
    for (int i = 0; i < 24; i++) begin
      a   = $urandom;
      sel = $urandom_range(0, 7);
      s   = 1'($urandom_range(0, 1));
      if (sel == 0)      b = 32'd0;
      else if (sel < 4)  b = 32'($urandom_range(1, 20));
      else               b = $urandom;
      if (s && sel == 1) b = -b;
      run_div($sformatf("rnd%0d", i), a, b, s);
    end

    // Asynchronous reset in the middle of BUSY.
    run_div("pre_rst", 32'd1000, 32'd3, 1'b0);
    @(negedge clk);
    startE = 1'b1;
    srcaE  = 32'd50;
    srcbE  = 32'd6;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst.lo", lo, 32'd0);
    check("arst.hi", hi, 32'd0);
    check("arst.ready", {31'd0, ready}, 32'd0);
    check("arst.stall", {31'd0, stall_div}, 32'd0);
    startE = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check("post_rst.stall", {31'd0, stall_div}, 32'd0);
      check("post_rst.ready", {31'd0, ready}, 32'd0);
    end
    run_div("after_rst", 32'hFFFF_FF9C, 32'd7, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
